// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor_cell.sv
// One-bit half subtractor: difference and borrow of x - y.
module half_subtractor_cell (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_half_subtractor.sv
// Bit-serial A - B, LSB first over WIDTH cycles, with start/busy/done handshake.
// The result and final borrow are held until the next operation completes.
module serial_half_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_d_sr;
    logic               r_bor;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_t;
    logic               w_b1;
    logic               w_d;
    logic               w_b2;
    logic               w_last;

    // Two chained half subtractors plus an OR form one full-subtract slice.
    half_subtractor_cell u_hs1 (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .d  (w_t),
        .bo (w_b1)
    );

    half_subtractor_cell u_hs2 (
        .x  (w_t),
        .y  (r_bor),
        .d  (w_d),
        .bo (w_b2)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accepted start, shift one bit per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr <= a_in;
                        r_b_sr <= b_in;
                        r_d_sr <= '0;
                        r_bor  <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_bor  <= w_b1 | w_b2;
                    r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff   <= {w_d, r_d_sr[WIDTH-1:1]};
                        r_borrow <= w_b1 | w_b2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Directed and random checks of serial_half_subtractor against a cycle model and result scoreboard.
module tb_serial_half_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_checks = 0;
    int n_pass   = 0;
    int m_cnt    = 0;
    int done_seen = 0;

    logic [W:0]   sb_q[$];
    logic [W:0]   sb_item;
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;

    serial_half_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Cycle model: 1..W = shifting, W+1 = done cycle, 0 = idle. Pushes the expected result on acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            sb_q.delete();
        end else if (m_cnt == 0) begin
            if (start) begin
                sb_q.push_back({a_in < b_in, W'(a_in - b_in)});
                m_cnt <= 1;
            end
        end else if (m_cnt == W + 1) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Checker on the falling edge: handshake timing, result on done, and result hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            hold_d = '0;
            hold_b = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == W + 1));
            if (m_cnt == W + 1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $error("FAIL sb_empty observed=0 expected=1 queued results");
                end else begin
                    sb_item = sb_q.pop_front();
                    hold_d  = sb_item[W-1:0];
                    hold_b  = sb_item[W];
                end
            end
            if (done === 1'b1) done_seen++;
            chk("diff", 32'(diff), 32'(hold_d));
            chk("borrow_out", 32'(borrow_out), 32'(hold_b));
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    int d0;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_borrow", 32'(borrow_out), 32'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        op(8'd100, 8'd37);
        op(8'd5, 8'd9);
        op(8'd0, 8'd1);
        op(8'd255, 8'd255);

        // Starts during SHIFT and during DONE must be ignored.
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; a_in = 8'd200; b_in = 8'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a_in = 8'd1; b_in = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ignored_start_done_count", 32'(done_seen - d0), 32'(1));

        // Start held high: back-to-back operations every W+2 cycles.
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; a_in = 8'd10; b_in = 8'd3;
        repeat (3 * (W + 2)) @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("held_start_done_count", 32'(done_seen - d0), 32'(3));

        // Asynchronous reset in the middle of SHIFT.
        op(8'd9, 8'd4);
        @(negedge clk);
        start = 1'b1; a_in = 8'd3; b_in = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_diff", 32'(diff), 32'(0));
        chk("midrst_borrow", 32'(borrow_out), 32'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        op(8'd3, 8'd8);

        for (int i = 0; i < 1000; i++) begin
            op(W'($urandom), W'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
